// File: rtl/hsi_pkg.sv
// Shared constants, FSM state encoding and the shift helper for the HSI serial receiver.
package hsi_pkg;

    localparam int HSI_WORD_BITS            = 16;
    localparam int HSI_FIFO_DEPTH_DEFAULT   = 4;
    localparam int HSI_IDLE_TIMEOUT_DEFAULT = 8;

    typedef enum logic [1:0] {
        HSI_IDLE = 2'd0,
        HSI_RECV = 2'd1,
        HSI_PUSH = 2'd2
    } hsi_state_e;

    function automatic logic [HSI_WORD_BITS-1:0] hsi_shift_in(
        input logic [HSI_WORD_BITS-1:0] shift,
        input logic                     bit_in
    );
        return {shift[HSI_WORD_BITS-2:0], bit_in};
    endfunction

endpackage

// File: rtl/hsi_stream_receiver_if.sv
// Parallel output stream of the HSI receiver.
interface hsi_stream_receiver_if;
    import hsi_pkg::*;

    // A word transfers on every clock where m_valid and m_ready are both high;
    // m_data must stay stable while m_valid is high and m_ready is low.
    logic [HSI_WORD_BITS-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/hsi_rx_fifo.sv
// Synchronous show-ahead FIFO holding completed receive words.
module hsi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/hsi_stream_receiver.sv
// HSI serial receiver: synchronizes HSCK/HSDATA, assembles 16-bit MSB-first words
// and queues them in a FIFO with word counting, overflow and frame-timeout flags.
module hsi_stream_receiver
    import hsi_pkg::*;
#(
    parameter int FIFO_DEPTH   = HSI_FIFO_DEPTH_DEFAULT,
    parameter int IDLE_TIMEOUT = HSI_IDLE_TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  HSCK_POL,
    input  logic                  HSCK,
    input  logic                  HSDATA,
    hsi_stream_receiver_if.master m_stream,
    output logic [15:0]           word_count,
    output logic                  overflow,
    output logic                  frame_error,
    output logic                  busy,
    output logic [1:0]            fsm_state
);
    localparam logic [1:0] ST_IDLE = HSI_IDLE;
    localparam logic [1:0] ST_RECV = HSI_RECV;
    localparam logic [1:0] ST_PUSH = HSI_PUSH;
    localparam int         TW      = $clog2(IDLE_TIMEOUT + 1);

    logic                     hsck_s1, hsck_s2, data_s1, data_s2;
    logic                     eff_hsck, eff_prev, sample_edge;
    logic [1:0]               state;
    logic [4:0]               bit_cnt;
    logic [TW-1:0]            idle_cnt;
    logic [HSI_WORD_BITS-1:0] shift;
    logic                     push_req, pop_req, push_ok;
    logic                     fifo_full, fifo_empty;
    logic [HSI_WORD_BITS-1:0] fifo_data;

    assign eff_hsck    = hsck_s2 ^ HSCK_POL;
    assign sample_edge = enable && eff_prev && !eff_hsck;

    // Clock and data share the same synchronizer depth so each sample stays aligned;
    // eff_prev tracks continuously so arming or a polarity change never looks like an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsck_s1  <= 1'b0;
            hsck_s2  <= 1'b0;
            data_s1  <= 1'b0;
            data_s2  <= 1'b0;
            eff_prev <= 1'b0;
        end else begin
            hsck_s1  <= HSCK;
            hsck_s2  <= hsck_s1;
            data_s1  <= HSDATA;
            data_s2  <= data_s1;
            eff_prev <= eff_hsck;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            shift       <= '0;
            frame_error <= 1'b0;
        end else if (clear) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
            frame_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idle_cnt <= '0;
                    if (sample_edge) begin
                        shift   <= hsi_shift_in(shift, data_s2);
                        bit_cnt <= 5'd1;
                        state   <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (!enable) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        idle_cnt <= '0;
                    end else if (sample_edge) begin
                        shift    <= hsi_shift_in(shift, data_s2);
                        bit_cnt  <= bit_cnt + 5'd1;
                        idle_cnt <= '0;
                        if (bit_cnt == 5'd15) begin
                            state <= ST_PUSH;
                        end
                    end else if (idle_cnt == TW'(IDLE_TIMEOUT - 1)) begin
                        // Sender stalled mid-word: drop the partial word.
                        state       <= ST_IDLE;
                        bit_cnt     <= '0;
                        idle_cnt    <= '0;
                        frame_error <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                ST_PUSH: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign push_req = (state == ST_PUSH);
    assign pop_req  = m_stream.m_ready && !fifo_empty;
    assign push_ok  = push_req && (!fifo_full || pop_req);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
            overflow   <= 1'b0;
        end else if (clear) begin
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                word_count <= word_count + 16'd1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    hsi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (HSI_WORD_BITS)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (push_req),
        .push_data (shift),
        .pop       (pop_req),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign m_stream.m_data  = fifo_data;
    assign m_stream.m_valid = !fifo_empty;
    assign busy             = (bit_cnt != 5'd0);
    assign fsm_state        = state;

endmodule

// File: tb/tb_hsi_stream_receiver.sv
// Directed and randomized checks of hsi_stream_receiver against a word-level queue model.
module tb_hsi_stream_receiver;
    import hsi_pkg::*;

    localparam int DEPTH = 4;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic        clear    = 1'b0;
    logic        hsck_pol = 1'b0;
    logic        hsck     = 1'b0;
    logic        hsdata   = 1'b0;
    logic [15:0] word_count;
    logic        overflow, frame_error, busy;
    logic [1:0]  fsm_state;

    hsi_stream_receiver_if bus ();

    hsi_stream_receiver dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear       (clear),
        .HSCK_POL    (hsck_pol),
        .HSCK        (hsck),
        .HSDATA      (hsdata),
        .m_stream    (bus),
        .word_count  (word_count),
        .overflow    (overflow),
        .frame_error (frame_error),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] wc_exp  = '0;
    logic        ovf_exp = 1'b0;
    logic        fe_exp  = 1'b0;
    int          ready_mode = 0;   // 0 hold off, 1 always ready, 2 random, 3 ready only during push
    logic [15:0] obs_mem [256];
    int          obs_n = 0;
    int          obs_rd = 0;
    int          valid_cycles = 0;

    always @(posedge clock) begin
        #1;
        case (ready_mode)
            0:       bus.m_ready = 1'b0;
            1:       bus.m_ready = 1'b1;
            2:       bus.m_ready = 1'($urandom_range(0, 1));
            default: bus.m_ready = (fsm_state == HSI_PUSH);
        endcase
    end

    always @(negedge clock) begin
        if (reset_n === 1'b1 && bus.m_valid === 1'b1) begin
            valid_cycles = valid_cycles + 1;
            if (bus.m_ready === 1'b1) begin
                obs_mem[obs_n % 256] = bus.m_data;
                obs_n = obs_n + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] w, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            hsdata = w[15-i];
            hsck   = ~hsck_pol;
            wait_clk(half);
            hsck   = hsck_pol;
            wait_clk(half);
        end
    endtask

    // Model: a finished word is accepted unless the FIFO already holds DEPTH words
    // and nothing leaves in the push cycle.
    task automatic send_word(input logic [15:0] w, input int half, input bit simul_pop);
        int occ;
        send_bits(w, 16, half);
        occ = exp_q.size() - (obs_n - obs_rd);
        if (occ < DEPTH || simul_pop) begin
            exp_q.push_back(w);
            wc_exp = wc_exp + 16'd1;
        end else begin
            ovf_exp = 1'b1;
        end
        wait_clk(6);
    endtask

    task automatic check_pops(input string tag);
        while (obs_rd < obs_n) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_errors++;
                $error("FAIL %s_extra: observed word %0h expected no word", tag, obs_mem[obs_rd % 256]);
            end
            if (exp_q.size() > 0) begin
                check(tag, {16'h0, obs_mem[obs_rd % 256]}, {16'h0, exp_q.pop_front()});
            end
            obs_rd++;
        end
    endtask

    task automatic drain_check(input string tag);
        wait_clk(4);
        check_pops(tag);
        check({tag, "_left"}, exp_q.size(), 0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_wc"}, {16'h0, word_count}, {16'h0, wc_exp});
        check({tag, "_ovf"}, {31'h0, overflow}, {31'h0, ovf_exp});
        check({tag, "_fe"}, {31'h0, frame_error}, {31'h0, fe_exp});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        wait_clk(1);
        clear = 1'b0;
        exp_q.delete();
        obs_rd  = obs_n;
        wc_exp  = '0;
        ovf_exp = 1'b0;
        fe_exp  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'h0, bus.m_valid}, 0);
        check({tag, "_data"}, {16'h0, bus.m_data}, 0);
        check({tag, "_busy"}, {31'h0, busy}, 0);
        check({tag, "_state"}, {30'h0, fsm_state}, {30'h0, HSI_IDLE});
        check_status(tag);
    endtask

    initial begin
        int          v0;
        logic [15:0] w;

        ready_mode = 1;
        wait_clk(3);
        check_zero("reset");
        reset_n = 1'b1;
        enable  = 1'b1;
        wait_clk(3);

        // Single word at 2 clocks per bit; valid lasts one cycle with ready held high.
        v0 = valid_cycles;
        send_word(16'h9381, 1, 1'b0);
        drain_check("s033_word");
        check("s033_valid_pulse", valid_cycles - v0, 1);
        check_status("s033");

        // Inverted polarity: a falling effective edge while disarmed must be ignored.
        do_clear();
        enable   = 1'b0;
        hsck_pol = 1'b1;
        wait_clk(4);
        hsck     = 1'b1;
        wait_clk(4);
        enable   = 1'b1;
        wait_clk(4);
        check("s034_arm_busy", {31'h0, busy}, 0);
        check("s034_arm_valid", {31'h0, bus.m_valid}, 0);
        send_word(16'h0003, 2, 1'b0);
        send_word(16'h0002, 2, 1'b0);
        send_word(16'h0001, 2, 1'b0);
        drain_check("s034_word");
        check_status("s034");
        enable   = 1'b0;
        hsck_pol = 1'b0;
        hsck     = 1'b0;
        wait_clk(4);
        enable   = 1'b1;
        wait_clk(2);

        // Random words, random bit rates, random back-pressure.
        do_clear();
        ready_mode = 2;
        for (int i = 0; i < 6; i++) begin
            send_word(16'($urandom), $urandom_range(1, 3), 1'b0);
        end
        ready_mode = 1;
        drain_check("rand_word");
        check_status("rand");

        // Overflow: five words into four entries with no consumer.
        do_clear();
        ready_mode = 0;
        for (int i = 0; i < 5; i++) begin
            send_word(16'($urandom), 1, 1'b0);
        end
        check_status("s035");
        check("s035_valid", {31'h0, bus.m_valid}, 1);
        check("s035_head", {16'h0, bus.m_data}, {16'h0, exp_q[0]});
        wait_clk(3);
        check("s035_head_held", {16'h0, bus.m_data}, {16'h0, exp_q[0]});
        ready_mode = 1;
        drain_check("s035_word");
        check_status("s035_drained");

        // Full FIFO with push and pop in the same cycle, then clear flushes it.
        do_clear();
        check_status("s038_cleared");
        ready_mode = 0;
        for (int i = 0; i < 4; i++) begin
            send_word(16'($urandom), 1, 1'b0);
        end
        check_status("s038_full");
        ready_mode = 3;
        send_word(16'($urandom), 1, 1'b1);
        ready_mode = 0;
        wait_clk(2);
        check_pops("s038_pop");
        check("s038_entries", exp_q.size(), 4);
        check_status("s038_simul");
        check("s038_head", {16'h0, bus.m_data}, {16'h0, exp_q[0]});
        do_clear();
        check("s038_clr_valid", {31'h0, bus.m_valid}, 0);
        check_status("s038_clr");

        // Stalled sender: partial word times out, next word is still clean.
        ready_mode = 1;
        send_bits(16'($urandom), 7, 1);
        wait_clk(2);
        check("s036_busy_mid", {31'h0, busy}, 1);
        wait_clk(30);
        fe_exp = 1'b1;
        check("s036_busy_after", {31'h0, busy}, 0);
        check_status("s036_timeout");
        send_word(16'hA5A5, 1, 1'b0);
        drain_check("s036_word");
        check_status("s036");

        // Asynchronous reset mid-word.
        send_bits(16'($urandom), 9, 1);
        wait_clk(1);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        wc_exp  = '0;
        ovf_exp = 1'b0;
        fe_exp  = 1'b0;
        check_zero("s037_reset");
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2);
        send_word(16'h1234, 1, 1'b0);
        drain_check("s037_word");
        check_status("s037");

        // Disarming mid-word drops it silently and keeps queued words.
        ready_mode = 0;
        w = 16'($urandom);
        send_word(w, 1, 1'b0);
        send_bits(16'($urandom), 5, 1);
        wait_clk(3);
        check("dis_busy_mid", {31'h0, busy}, 1);
        enable = 1'b0;
        wait_clk(2);
        check("dis_busy", {31'h0, busy}, 0);
        check("dis_kept", {16'h0, bus.m_data}, {16'h0, w});
        enable = 1'b1;
        wait_clk(2);
        send_word(16'($urandom), 2, 1'b0);
        check_status("dis");
        ready_mode = 1;
        drain_check("dis_word");

        check("final_pending", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
